pcie_flow_ctrl_rx: RTL and testbench
====================================

PCIE_FLOW_CTRL_RX -- requirements
Module: pcie_flow_ctrl_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, received DLLP stream data width.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 3, tuser width (ignored).
REQ-004 SHALL have port clk_i, in, 1, the only clock.
REQ-005 SHALL have port rst_i, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port flow_ctrl_clear_i, in, 1, synchronous clear of all stored credits and flags (link down).
REQ-007 SHALL have ports s_axis_tdata/tkeep/tvalid/tlast/tuser, in, DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH, received DLLP stream.
REQ-008 SHALL have port s_axis_tready, out, 1, stream ready.
REQ-009 SHALL have ports p_hdr_o, np_hdr_o, cpl_hdr_o, out, 8 each, stored header credit limits.
REQ-010 SHALL have ports p_data_o, np_data_o, cpl_data_o, out, 12 each, stored data credit limits.
REQ-011 SHALL have ports fc1_values_stored_o and fc2_values_stored_o, out, 1 each, init-phase completion flags.
REQ-012 SHALL have ports update_fc_o (1-cycle pulse on an accepted UpdateFC), crc_err_o and malformed_o, out, 1 each.

Function
REQ-013 Framing SHALL be one DLLP per two beats: beat 0 is the 4 DLLP bytes (byte 0 in tdata[7:0]); beat 1 is the 16-bit CRC in tdata[15:0] with tlast=1.
REQ-014 s_axis_tready SHALL be 1 whenever rst_i is high; the block never back-pressures.
REQ-015 FSM states SHALL be ST_HDR, ST_CRC and ST_DRAIN; reset state ST_HDR.
REQ-016 ST_HDR: an accepted beat with tlast=0 SHALL register the dword and the CRC result, then go to ST_CRC.
REQ-017 The CRC result SHALL come from a pcie_datalink_crc instance with crcIn all ones over beat-0 data.
REQ-018 ST_HDR: an accepted beat with tlast=1 SHALL pulse malformed_o, discard the beat and stay in ST_HDR.
REQ-019 ST_CRC: an accepted beat with tlast=1 SHALL compare tdata[15:0] with the bitwise inverse of the registered CRC, then return to ST_HDR.
REQ-020 On CRC mismatch, crc_err_o SHALL pulse for 1 cycle and the DLLP SHALL be discarded.
REQ-021 ST_CRC: an accepted beat with tlast=0 SHALL pulse malformed_o, discard the DLLP and go to ST_DRAIN.
REQ-022 ST_DRAIN SHALL discard beats until an accepted tlast=1 beat, then return to ST_HDR.
REQ-023 Decode on good CRC: type = byte0[7:4]; VC = byte0[2:0]; HdrFC = {byte1[5:0], byte2[7:6]}; DataFC = {byte2[3:0], byte3}.
REQ-024 Type codes SHALL be: InitFC1 P/NP/Cpl = 4/5/6; InitFC2 = C/D/E; UpdateFC = 8/9/A.
REQ-025 DLLPs with VC != 0 or any other type SHALL be silently ignored.
REQ-026 InitFC1 or InitFC2 of a class whose seen bit is clear SHALL latch both credit fields and set that bit.
REQ-027 Repeated InitFC1/InitFC2 of an already-seen class SHALL leave stored values unchanged.
REQ-028 fc1_values_stored_o SHALL set once all three seen bits are set.
REQ-029 fc2_values_stored_o SHALL set on the first InitFC2 or UpdateFC received while fc1_values_stored_o is 1.
REQ-030 A fc2-qualifying DLLP arriving in the same cycle fc1_values_stored_o sets SHALL not count toward fc2_values_stored_o.
REQ-031 UpdateFC while fc2_values_stored_o=1 SHALL overwrite that class's credits and pulse update_fc_o; otherwise it SHALL be ignored for credits.
REQ-032 Latency: credits, flags and pulses SHALL update on the clock edge after the beat-1 handshake.
REQ-033 flow_ctrl_clear_i SHALL clear credits, seen bits and flags and force ST_HDR; it wins over a same-cycle DLLP completion.

Reset
REQ-034 While rst_i=0, asynchronously: FSM=ST_HDR, all credits=0, seen bits=0, all flags and pulses=0, s_axis_tready=0.
REQ-035 Reset asserted mid-DLLP SHALL discard the partial DLLP.

Verification
REQ-036 InitFC1 P/NP/Cpl with valid CRC; P beat 0 tdata=0x10000240 -> p_hdr_o=8, p_data_o=16; fc1_values_stored_o=1 one cycle after the third CRC beat.
REQ-037 Same P DLLP with CRC bit 0 flipped -> crc_err_o pulses once; p_hdr_o stays 0.
REQ-038 After FC1 complete, InitFC2 P with HdrFC=0x20 -> fc2_values_stored_o=1; p_hdr_o stays 8.
REQ-039 After FC2 complete, UpdateFC Cpl with HdrFC=0x15, DataFC=0x123 -> cpl_hdr_o=0x15, cpl_data_o=0x123, update_fc_o one pulse.
REQ-040 Single beat tlast=1 -> malformed_o pulses; a 3-beat packet -> malformed_o pulses once, ST_DRAIN exits on tlast; next valid DLLP is decoded.
REQ-041 Reset and flow_ctrl_clear_i each asserted between beat 0 and beat 1 -> no credits stored; flags 0; next DLLP decodes normally.

Source files
------------

// File: rtl/pcie_flow_ctrl_rx.sv
// ---------------------------------------------------------------------------
// pcie_flow_ctrl_rx
//   Receives data-link-layer packets (DLLPs) from an AXI-stream, checks the
//   16-bit link CRC, decodes flow-control DLLPs for VC0 and keeps the
//   advertised credit limits of the link partner.
//
//   Framing: two beats per DLLP. Beat 0 carries the four DLLP bytes (byte 0
//   in tdata[7:0]). Beat 1 carries the transmitted CRC in tdata[15:0] and
//   has tlast=1.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-low reset
//   flow_ctrl_clear_i      synchronous clear of credits and flags (link down)
//   s_axis_*               received DLLP stream; tready=rst_i (no back-pressure)
//   p/np/cpl_hdr_o         stored header credit limits (8 bit)
//   p/np/cpl_data_o        stored data credit limits (12 bit)
//   fc1/fc2_values_stored_o  init-phase completion flags
//   update_fc_o            1-cycle pulse on an accepted UpdateFC
//   crc_err_o              1-cycle pulse on a DLLP with bad CRC
//   malformed_o            1-cycle pulse on a framing error
// ---------------------------------------------------------------------------

// Link CRC over one 32-bit DLLP body. Polynomial x^16+x^12+x^3+x+1 (100Bh);
// data bits enter in wire order, tdata[0] first.
module pcie_datalink_crc (
  input  logic [15:0] crc_in,
  input  logic [31:0] data_in,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc16_dw(input logic [15:0] seed,
                                           input logic [31:0] data);
    logic [15:0] crc;
    logic        fb;
    crc = seed;
    for (int k = 0; k < 32; k++) begin
      fb  = crc[15] ^ data[k];
      crc = {crc[14:0], 1'b0};
      if (fb) begin
        crc = crc ^ 16'h100B;
      end else begin
        crc = crc;
      end
    end
    return crc;
  endfunction

  assign crc_out = crc16_dw(crc_in, data_in);

endmodule

module pcie_flow_ctrl_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flow_ctrl_clear_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [7:0]            p_hdr_o,
  output logic [7:0]            np_hdr_o,
  output logic [7:0]            cpl_hdr_o,
  output logic [11:0]           p_data_o,
  output logic [11:0]           np_data_o,
  output logic [11:0]           cpl_data_o,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic                  update_fc_o,
  output logic                  crc_err_o,
  output logic                  malformed_o
);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_CRC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [31:0]      dword_r;
  logic [15:0]      crc_r;
  logic [15:0]      crc_s;
  logic             beat_s;
  logic             load_s;
  logic             done_s;
  logic             malformed_s;
  logic             crc_ok_s;
  logic             crc_bad_s;
  logic             dllp_ok_s;

  logic             is_init_s;   // InitFC1 or InitFC2
  logic             is_fc2q_s;   // InitFC2 or UpdateFC (qualifies for fc2 flag)
  logic             is_upd_s;    // UpdateFC
  logic [2:0]       sel_s;       // one-hot class: {Cpl, NP, P}
  logic [7:0]       hdr_fc_s;
  logic [11:0]      data_fc_s;

  logic [2:0][7:0]  hdr_r, hdr_s;
  logic [2:0][11:0] data_r, data_s;
  logic [2:0]       seen_r, seen_s;
  logic             fc1_r, fc1_s;
  logic             fc2_r, fc2_s;
  logic             upd_s;
  logic             upd_r, crc_err_r, malformed_r;

  // tkeep/tuser carry nothing for this framing; upper tdata bits are unused.
  logic unused_s;
  assign unused_s = ^{s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  assign s_axis_tready = rst_i;
  assign beat_s        = s_axis_tvalid & s_axis_tready;

  pcie_datalink_crc u_crc (
    .crc_in  (16'hFFFF),
    .data_in (s_axis_tdata[31:0]),
    .crc_out (crc_s)
  );

  // Framing FSM: next state and beat classification.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    done_s      = 1'b0;
    malformed_s = 1'b0;
    case (state_r)
      ST_HDR: begin
        if (beat_s && s_axis_tlast) begin
          malformed_s = 1'b1;
        end else if (beat_s) begin
          load_s  = 1'b1;
          state_s = ST_CRC;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_CRC: begin
        if (beat_s && s_axis_tlast) begin
          done_s  = 1'b1;
          state_s = ST_HDR;
        end else if (beat_s) begin
          malformed_s = 1'b1;
          state_s     = ST_DRAIN;
        end else begin
          state_s = ST_CRC;
        end
      end
      ST_DRAIN: begin
        if (beat_s && s_axis_tlast) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_HDR;
    endcase
  end

  // The transmitter sends the complement of the running CRC.
  assign crc_ok_s  = done_s & (s_axis_tdata[15:0] == ~crc_r);
  assign crc_bad_s = done_s & ~crc_ok_s;
  assign dllp_ok_s = crc_ok_s & (dword_r[2:0] == 3'd0);

  assign hdr_fc_s  = {dword_r[13:8], dword_r[23:22]};
  assign data_fc_s = {dword_r[19:16], dword_r[31:24]};

  // DLLP type decode into kind flags and one-hot credit class.
  always_comb begin
    is_init_s = 1'b0;
    is_fc2q_s = 1'b0;
    is_upd_s  = 1'b0;
    sel_s     = 3'b000;
    case (dword_r[7:4])
      4'h4: begin is_init_s = 1'b1; sel_s = 3'b001; end
      4'h5: begin is_init_s = 1'b1; sel_s = 3'b010; end
      4'h6: begin is_init_s = 1'b1; sel_s = 3'b100; end
      4'hC: begin is_init_s = 1'b1; is_fc2q_s = 1'b1; sel_s = 3'b001; end
      4'hD: begin is_init_s = 1'b1; is_fc2q_s = 1'b1; sel_s = 3'b010; end
      4'hE: begin is_init_s = 1'b1; is_fc2q_s = 1'b1; sel_s = 3'b100; end
      4'h8: begin is_upd_s = 1'b1; is_fc2q_s = 1'b1; sel_s = 3'b001; end
      4'h9: begin is_upd_s = 1'b1; is_fc2q_s = 1'b1; sel_s = 3'b010; end
      4'hA: begin is_upd_s = 1'b1; is_fc2q_s = 1'b1; sel_s = 3'b100; end
      default: sel_s = 3'b000;
    endcase
  end

  // Credit and flag next-state. Flags are tested on their current value so a
  // DLLP that completes FC1 cannot also complete FC2.
  always_comb begin
    seen_s = seen_r;
    for (int i = 0; i < 3; i++) begin
      if (dllp_ok_s && is_init_s && sel_s[i] && !seen_r[i]) begin
        hdr_s[i]  = hdr_fc_s;
        data_s[i] = data_fc_s;
        seen_s[i] = 1'b1;
      end else if (dllp_ok_s && is_upd_s && sel_s[i] && fc2_r) begin
        hdr_s[i]  = hdr_fc_s;
        data_s[i] = data_fc_s;
      end else begin
        hdr_s[i]  = hdr_r[i];
        data_s[i] = data_r[i];
      end
    end
    upd_s = dllp_ok_s & is_upd_s & fc2_r;
    fc2_s = fc2_r | (dllp_ok_s & is_fc2q_s & fc1_r);
    fc1_s = fc1_r | (&seen_s);
  end

  // FSM state and beat-0 capture (dword plus its CRC).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_HDR;
      dword_r <= 32'd0;
      crc_r   <= 16'd0;
    end else if (flow_ctrl_clear_i) begin
      state_r <= ST_HDR;
      dword_r <= 32'd0;
      crc_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        dword_r <= s_axis_tdata[31:0];
        crc_r   <= crc_s;
      end
    end
  end

  // Stored credits, init flags and status pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hdr_r       <= '0;
      data_r      <= '0;
      seen_r      <= 3'b000;
      fc1_r       <= 1'b0;
      fc2_r       <= 1'b0;
      upd_r       <= 1'b0;
      crc_err_r   <= 1'b0;
      malformed_r <= 1'b0;
    end else if (flow_ctrl_clear_i) begin
      hdr_r       <= '0;
      data_r      <= '0;
      seen_r      <= 3'b000;
      fc1_r       <= 1'b0;
      fc2_r       <= 1'b0;
      upd_r       <= 1'b0;
      crc_err_r   <= 1'b0;
      malformed_r <= 1'b0;
    end else begin
      hdr_r       <= hdr_s;
      data_r      <= data_s;
      seen_r      <= seen_s;
      fc1_r       <= fc1_s;
      fc2_r       <= fc2_s;
      upd_r       <= upd_s;
      crc_err_r   <= crc_bad_s;
      malformed_r <= malformed_s;
    end
  end

  assign p_hdr_o             = hdr_r[0];
  assign np_hdr_o            = hdr_r[1];
  assign cpl_hdr_o           = hdr_r[2];
  assign p_data_o            = data_r[0];
  assign np_data_o           = data_r[1];
  assign cpl_data_o          = data_r[2];
  assign fc1_values_stored_o = fc1_r;
  assign fc2_values_stored_o = fc2_r;
  assign update_fc_o         = upd_r;
  assign crc_err_o           = crc_err_r;
  assign malformed_o         = malformed_r;

endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// ---------------------------------------------------------------------------
// tb_pcie_flow_ctrl_rx
//   Directed scenarios followed by randomized DLLP traffic, all checked
//   against a behavioural model of the credit store. The expected link CRC is
//   computed by polynomial long division of the augmented message.
// ---------------------------------------------------------------------------
module tb_pcie_flow_ctrl_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fc_clear = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic [3:0]  tkeep = 4'hF;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [2:0]  tuser = 3'd0;
  logic        tready;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr;
  logic [11:0] p_data, np_data, cpl_data;
  logic        fc1, fc2, upd, crc_err, malformed;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_hdr  [3];
  int m_data [3];
  bit m_seen [3];
  bit m_fc1, m_fc2;

  always #5 clk = ~clk;

  pcie_flow_ctrl_rx #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .flow_ctrl_clear_i   (fc_clear),
    .s_axis_tdata        (tdata),
    .s_axis_tkeep        (tkeep),
    .s_axis_tvalid       (tvalid),
    .s_axis_tlast        (tlast),
    .s_axis_tuser        (tuser),
    .s_axis_tready       (tready),
    .p_hdr_o             (p_hdr),
    .np_hdr_o            (np_hdr),
    .cpl_hdr_o           (cpl_hdr),
    .p_data_o            (p_data),
    .np_data_o           (np_data),
    .cpl_data_o          (cpl_data),
    .fc1_values_stored_o (fc1),
    .fc2_values_stored_o (fc2),
    .update_fc_o         (upd),
    .crc_err_o           (crc_err),
    .malformed_o         (malformed)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remainder of (msg*x^16 with 0xFFFF preset on the first 16 bits) mod 100Bh.
  function automatic logic [15:0] ref_crc(input logic [31:0] dw);
    logic [47:0] v;
    logic [47:0] poly;
    v = 48'd0;
    for (int k = 0; k < 32; k++) v[47-k] = dw[k];
    v[47:32] = v[47:32] ^ 16'hFFFF;
    for (int i = 47; i >= 16; i--) begin
      poly = 48'h1100B << (i - 16);
      if (v[i]) v = v ^ poly;
    end
    return v[15:0];
  endfunction

  function automatic logic [31:0] mk_dllp(input int typ, input int vc, input int hdr, input int dat);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] junk;
    logic [7:0] h;
    logic [11:0] d;
    junk = 8'($urandom);
    h  = 8'(hdr);
    d  = 12'(dat);
    b0 = {4'(typ), junk[0], 3'(vc)};
    b1 = {junk[2:1], h[7:2]};
    b2 = {h[1:0], junk[4:3], d[11:8]};
    b3 = d[7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_hdr[i] = 0; m_data[i] = 0; m_seen[i] = 1'b0;
    end
    m_fc1 = 1'b0;
    m_fc2 = 1'b0;
  endtask

  task automatic model_dllp(input logic [31:0] dw, input bit good, output bit e_err, output bit e_upd);
    int typ, vc, hdr, dat, cls;
    bit old_fc1, old_fc2;
    typ = int'(dw[7:4]);
    vc  = int'(dw[2:0]);
    hdr = int'(dw[15:8] & 8'h3F) * 4 + int'(dw[23:16]) / 64;
    dat = int'(dw[23:16] & 8'h0F) * 256 + int'(dw[31:24]);
    e_err = !good;
    e_upd = 1'b0;
    if (good && vc == 0) begin
      old_fc1 = m_fc1;
      old_fc2 = m_fc2;
      if ((typ >= 4 && typ <= 6) || (typ >= 12 && typ <= 14)) begin
        cls = (typ >= 12) ? typ - 12 : typ - 4;
        if (!m_seen[cls]) begin
          m_hdr[cls] = hdr; m_data[cls] = dat; m_seen[cls] = 1'b1;
        end
      end
      if (((typ >= 12 && typ <= 14) || (typ >= 8 && typ <= 10)) && old_fc1) m_fc2 = 1'b1;
      if (typ >= 8 && typ <= 10 && old_fc2) begin
        cls = typ - 8;
        m_hdr[cls] = hdr; m_data[cls] = dat; e_upd = 1'b1;
      end
      m_fc1 = m_seen[0] && m_seen[1] && m_seen[2];
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".p_hdr"},    32'(p_hdr),    32'(m_hdr[0]));
    check_val({tag, ".np_hdr"},   32'(np_hdr),   32'(m_hdr[1]));
    check_val({tag, ".cpl_hdr"},  32'(cpl_hdr),  32'(m_hdr[2]));
    check_val({tag, ".p_data"},   32'(p_data),   32'(m_data[0]));
    check_val({tag, ".np_data"},  32'(np_data),  32'(m_data[1]));
    check_val({tag, ".cpl_data"}, 32'(cpl_data), 32'(m_data[2]));
    check_val({tag, ".fc1"},      32'(fc1),      32'(m_fc1));
    check_val({tag, ".fc2"},      32'(fc2),      32'(m_fc2));
  endtask

  task automatic check_pulses(input string tag, input bit e_mal, input bit e_err, input bit e_upd);
    check_val({tag, ".malformed"}, 32'(malformed), 32'(e_mal));
    check_val({tag, ".crc_err"},   32'(crc_err),   32'(e_err));
    check_val({tag, ".update_fc"}, 32'(upd),       32'(e_upd));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] data, input bit last);
    tdata  = data;
    tlast  = last;
    tuser  = 3'($urandom);
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = $urandom;
  endtask

  task automatic send_dllp(input string tag, input logic [31:0] dw, input bit bad);
    logic [15:0] c;
    logic [15:0] hi;
    bit e_err, e_upd;
    c = ~ref_crc(dw);
    if (bad) c = c ^ (16'd1 << $urandom_range(0, 15));
    hi = 16'($urandom);
    drive(dw, 1'b0);
    idle($urandom_range(0, 2));
    drive({hi, c}, 1'b1);
    model_dllp(dw, !bad, e_err, e_upd);
    check_pulses(tag, 1'b0, e_err, e_upd);
    check_state(tag);
    idle(1);
    check_pulses({tag, ".after"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_malformed_single(input string tag);
    drive($urandom, 1'b1);
    check_pulses(tag, 1'b1, 1'b0, 1'b0);
    idle(1);
    check_pulses({tag, ".after"}, 1'b0, 1'b0, 1'b0);
    check_state(tag);
  endtask

  task automatic send_long_packet(input string tag, input int extra);
    drive($urandom, 1'b0);
    drive($urandom, 1'b0);
    check_pulses({tag, ".b1"}, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < extra; i++) begin
      drive($urandom, 1'b0);
      check_pulses({tag, ".drain"}, 1'b0, 1'b0, 1'b0);
    end
    drive($urandom, 1'b1);
    check_pulses({tag, ".last"}, 1'b0, 1'b0, 1'b0);
    check_state(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, typ, vc;
    logic [31:0] dw;
    logic [3:0]  tsel;
    model_clear();
    #3;
    // reset state
    check_val("rst.tready", 32'(tready), 32'd0);
    check_state("rst");
    check_pulses("rst", 1'b0, 1'b0, 1'b0);
    idle(2);
    #2 rst_n = 1'b1;
    idle(1);
    check_val("tready", 32'(tready), 32'd1);

    // bad CRC on InitFC1 P
    send_dllp("p_badcrc", 32'h10000240, 1'b1);
    check_val("p_badcrc.hdr0", 32'(p_hdr), 32'd0);

    // InitFC1 P / NP / Cpl
    send_dllp("fc1_p", 32'h10000240, 1'b0);
    check_val("fc1_p.hdr8", 32'(p_hdr), 32'd8);
    check_val("fc1_p.data16", 32'(p_data), 32'd16);
    send_dllp("fc1_np", mk_dllp(5, 0, 8'h11, 12'h022), 1'b0);
    check_val("fc1_np.fc1", 32'(fc1), 32'd0);
    send_dllp("fc1_cpl", mk_dllp(6, 0, 8'h00, 12'h000), 1'b0);

    // InitFC2 P cannot overwrite
    send_dllp("fc2_p", mk_dllp(12, 0, 8'h20, 12'h040), 1'b0);
    check_val("fc2_p.fc2", 32'(fc2), 32'd1);
    check_val("fc2_p.hdr8", 32'(p_hdr), 32'd8);

    // UpdateFC Cpl
    send_dllp("upd_cpl", mk_dllp(10, 0, 8'h15, 12'h123), 1'b0);
    check_val("upd_cpl.hdr", 32'(cpl_hdr), 32'h15);
    check_val("upd_cpl.data", 32'(cpl_data), 32'h123);

    // framing errors
    send_malformed_single("mal1");
    send_long_packet("mal3", 0);
    send_long_packet("mal5", 2);
    send_dllp("post_mal", mk_dllp(8, 0, 8'h33, 12'h456), 1'b0);

    // reset between beat 0 and beat 1
    drive(mk_dllp(4, 0, 8'h44, 12'h055), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_val("midrst.tready", 32'(tready), 32'd0);
    check_state("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    send_dllp("after_rst", mk_dllp(4, 0, 8'h07, 12'h0AB), 1'b0);

    // clear between beat 0 and beat 1
    drive(mk_dllp(5, 0, 8'h66, 12'h077), 1'b0);
    fc_clear = 1'b1;
    idle(1);
    fc_clear = 1'b0;
    model_clear();
    check_state("midclr");
    send_dllp("after_clr", mk_dllp(5, 0, 8'h09, 12'h0CD), 1'b0);

    // clear wins over a completing DLLP
    dw = mk_dllp(4, 0, 8'h12, 12'h345);
    drive(dw, 1'b0);
    tdata = {16'd0, ~ref_crc(dw)};
    tlast = 1'b1; tvalid = 1'b1; fc_clear = 1'b1;
    idle(1);
    tvalid = 1'b0; tlast = 1'b0; fc_clear = 1'b0;
    model_clear();
    check_pulses("clr_win", 1'b0, 1'b0, 1'b0);
    check_state("clr_win");

    // InitFC2 completing FC1 does not also complete FC2
    send_dllp("q_p", mk_dllp(4, 0, 8'h01, 12'h002), 1'b0);
    send_dllp("q_np", mk_dllp(5, 0, 8'h03, 12'h004), 1'b0);
    send_dllp("q_cpl2", mk_dllp(14, 0, 8'h05, 12'h006), 1'b0);
    check_val("q_cpl2.fc1", 32'(fc1), 32'd1);
    check_val("q_cpl2.fc2", 32'(fc2), 32'd0);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 82) begin
        tsel = 4'($urandom_range(0, 11));
        case (tsel)
          4'd0: typ = 4;  4'd1: typ = 5;  4'd2: typ = 6;
          4'd3: typ = 12; 4'd4: typ = 13; 4'd5: typ = 14;
          4'd6: typ = 8;  4'd7: typ = 9;  4'd8: typ = 10;
          default: typ = $urandom_range(0, 15);
        endcase
        vc = ($urandom_range(0, 99) < 85) ? 0 : $urandom_range(0, 7);
        send_dllp("rnd", mk_dllp(typ, vc, $urandom_range(0, 255), $urandom_range(0, 4095)),
                  $urandom_range(0, 99) < 15);
      end else if (r < 90) begin
        send_malformed_single("rnd_mal1");
      end else if (r < 96) begin
        send_long_packet("rnd_long", $urandom_range(0, 2));
      end else begin
        fc_clear = 1'b1;
        idle(1);
        fc_clear = 1'b0;
        model_clear();
        check_state("rnd_clr");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
